// File: rtl/eth_tx_sched_if.sv
// Request/response bundle between the frame scheduler, the RX/ARP and channel logic, and the frame sender.
// The scheduler takes the master modport; the surrounding logic (or a bench) takes the slave modport.
interface eth_tx_sched_if;
    localparam int unsigned TYPE_W = 4;
    localparam int unsigned MAC_W  = 48;
    localparam int unsigned IP_W   = 32;
    localparam int unsigned DROP_W = 16;
    localparam int unsigned TMO_W  = 8;

    logic              arp_resp_req;
    logic [MAC_W-1:0]  peer_mac;
    logic [IP_W-1:0]   peer_ip;
    logic              arp_probe_req;
    logic              udp_req;
    logic [IP_W-1:0]   host_ip;
    logic [MAC_W-1:0]  host_mac;
    logic              host_mac_vld;
    logic              tx_vld;
    logic              tx_rdy;
    logic              tx_eop;
    logic [TYPE_W-1:0] pkt_type;
    logic              msync_n;
    logic [MAC_W-1:0]  target_mac;
    logic [IP_W-1:0]   target_ip;
    logic              busy;
    logic [DROP_W-1:0] udp_drop;
    logic [TMO_W-1:0]  timeout_cnt;

    modport master (
        input  arp_resp_req, peer_mac, peer_ip, arp_probe_req, udp_req,
               host_ip, host_mac, host_mac_vld, tx_vld, tx_rdy, tx_eop,
        output pkt_type, msync_n, target_mac, target_ip, busy, udp_drop, timeout_cnt
    );

    modport slave (
        output arp_resp_req, peer_mac, peer_ip, arp_probe_req, udp_req,
               host_ip, host_mac, host_mac_vld, tx_vld, tx_rdy, tx_eop,
        input  pkt_type, msync_n, target_mac, target_ip, busy, udp_drop, timeout_cnt
    );
endinterface

// File: rtl/eth_tx_sched.sv
// Fixed-priority scheduler feeding the Ethernet frame sender: ARP response > UDP > ARP probe,
// one frame at a time, with a launch watchdog and a forced inter-frame gap.
module eth_tx_sched #(
    parameter logic [15:0] IFG_CYCLES = 16'd12,
    parameter logic [19:0] TIMEOUT    = 20'd65535,
    parameter logic [47:0] HOST_MAC   = 48'hFFFF_FFFF_FFFF
) (
    input  logic           clk,
    input  logic           rst,
    eth_tx_sched_if.master sif
);
    localparam int unsigned TYPE_W = 4;
    localparam int unsigned MAC_W  = 48;
    localparam int unsigned IP_W   = 32;
    localparam int unsigned WD_W   = 20;
    localparam int unsigned GAP_W  = 16;
    localparam int unsigned DROP_W = 16;
    localparam int unsigned TMO_W  = 8;

    localparam logic [TYPE_W-1:0] PT_IDLE     = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] PT_ARP_REQ  = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] PT_ARP_RESP = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] PT_UDP      = TYPE_W'(3);

    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_SEND, ST_GAP} state_t;
    typedef enum logic [1:0] {SEL_ARP_RESP, SEL_UDP, SEL_PROBE} sel_t;

    state_t state, state_nx;
    sel_t   sel, sel_nx;

    logic              arp_resp_p, udp_p, probe_p;
    logic [MAC_W-1:0]  peer_mac_q;
    logic [IP_W-1:0]   peer_ip_q;
    logic [WD_W-1:0]   wd;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TYPE_W-1:0] pkt_type_q;
    logic              msync_n_q;
    logic [MAC_W-1:0]  target_mac_q;
    logic [IP_W-1:0]   target_ip_q;
    logic              busy_q;
    logic [DROP_W-1:0] udp_drop_q;
    logic [TMO_W-1:0]  timeout_cnt_q;

    logic frame_end_c, timeout_c, gap_done_c;
    logic launch_resp_c, launch_udp_c, launch_probe_c;

    assign frame_end_c    = sif.tx_vld & sif.tx_rdy & sif.tx_eop;
    assign timeout_c      = (wd == TIMEOUT);
    assign gap_done_c     = (gap_cnt == (IFG_CYCLES - GAP_W'(1)));
    assign launch_resp_c  = (state == ST_LAUNCH) && (sel == SEL_ARP_RESP);
    assign launch_udp_c   = (state == ST_LAUNCH) && (sel == SEL_UDP);
    assign launch_probe_c = (state == ST_LAUNCH) && (sel == SEL_PROBE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sel   <= SEL_ARP_RESP;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
        end
    end

    // Next state and frame selection; UDP waits for a resolved host MAC, the probe never does
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        case (state)
            ST_IDLE: begin
                if (arp_resp_p) begin
                    sel_nx   = SEL_ARP_RESP;
                    state_nx = ST_LAUNCH;
                end else if (udp_p && sif.host_mac_vld) begin
                    sel_nx   = SEL_UDP;
                    state_nx = ST_LAUNCH;
                end else if (probe_p) begin
                    sel_nx   = SEL_PROBE;
                    state_nx = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_nx = ST_SEND;
            ST_SEND:   if (frame_end_c || timeout_c) state_nx = ST_GAP;
            ST_GAP:    if (gap_done_c) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Pending flags, peer latch, frame outputs, watchdog, gap timer and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            arp_resp_p    <= 1'b0;
            udp_p         <= 1'b0;
            probe_p       <= 1'b0;
            peer_mac_q    <= '0;
            peer_ip_q     <= '0;
            wd            <= '0;
            gap_cnt       <= '0;
            pkt_type_q    <= PT_IDLE;
            msync_n_q     <= 1'b1;
            target_mac_q  <= '0;
            target_ip_q   <= '0;
            busy_q        <= 1'b0;
            udp_drop_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            if (sif.arp_resp_req) begin
                peer_mac_q <= sif.peer_mac;
                peer_ip_q  <= sif.peer_ip;
            end

            // A pulse coinciding with its own launch re-arms the flag instead of being lost
            arp_resp_p <= (arp_resp_p & ~launch_resp_c)  | sif.arp_resp_req;
            udp_p      <= (udp_p      & ~launch_udp_c)   | sif.udp_req;
            probe_p    <= (probe_p    & ~launch_probe_c) | sif.arp_probe_req;

            if (sif.udp_req && udp_p && !launch_udp_c && (udp_drop_q != '1))
                udp_drop_q <= udp_drop_q + DROP_W'(1);

            msync_n_q <= 1'b1;
            busy_q    <= (state_nx != ST_IDLE);

            case (state)
                ST_IDLE: wd <= '0;
                ST_LAUNCH: begin
                    wd <= wd + WD_W'(1);
                    case (sel)
                        SEL_ARP_RESP: begin
                            pkt_type_q   <= PT_ARP_RESP;
                            target_mac_q <= peer_mac_q;
                            target_ip_q  <= peer_ip_q;
                        end
                        SEL_UDP: begin
                            pkt_type_q   <= PT_UDP;
                            msync_n_q    <= 1'b0;
                            target_mac_q <= sif.host_mac;
                            target_ip_q  <= sif.host_ip;
                        end
                        default: begin
                            pkt_type_q   <= PT_ARP_REQ;
                            target_mac_q <= sif.host_mac_vld ? sif.host_mac : HOST_MAC;
                            target_ip_q  <= sif.host_ip;
                        end
                    endcase
                end
                ST_SEND: begin
                    wd <= wd + WD_W'(1);
                    if (frame_end_c || timeout_c) begin
                        pkt_type_q <= PT_IDLE;
                        gap_cnt    <= '0;
                        if (!frame_end_c && (timeout_cnt_q != '1))
                            timeout_cnt_q <= timeout_cnt_q + TMO_W'(1);
                    end
                end
                ST_GAP: gap_cnt <= gap_cnt + GAP_W'(1);
                default: wd <= '0;
            endcase
        end
    end

    assign sif.pkt_type    = pkt_type_q;
    assign sif.msync_n     = msync_n_q;
    assign sif.target_mac  = target_mac_q;
    assign sif.target_ip   = target_ip_q;
    assign sif.busy        = busy_q;
    assign sif.udp_drop    = udp_drop_q;
    assign sif.timeout_cnt = timeout_cnt_q;
endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed and randomized checks of eth_tx_sched against a frame-order model built from the
// priority, launch-latency, gap and watchdog rules.
`timescale 1ns/1ps
module tb_eth_tx_sched;
    localparam int unsigned IFG      = 12;
    localparam int unsigned TMO      = 100;
    localparam int unsigned WAIT_MAX = 400;
    localparam logic [47:0] BCAST    = 48'hFFFF_FFFF_FFFF;

    typedef struct {
        logic [3:0]  t;
        logic [47:0] mac;
        logic [31:0] ip;
    } frm_t;

    logic clk = 1'b0;
    logic rst;
    int   n_asrt = 0;
    int   n_fail = 0;

    eth_tx_sched_if sif ();

    eth_tx_sched #(
        .IFG_CYCLES (16'(IFG)),
        .TIMEOUT    (20'(TMO)),
        .HOST_MAC   (BCAST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic arp, input logic udp, input logic probe,
                         input logic [47:0] pmac, input logic [31:0] pip);
        sif.arp_resp_req  = arp;
        sif.udp_req       = udp;
        sif.arp_probe_req = probe;
        sif.peer_mac      = pmac;
        sif.peer_ip       = pip;
        step();
        sif.arp_resp_req  = 1'b0;
        sif.udp_req       = 1'b0;
        sif.arp_probe_req = 1'b0;
        sif.peer_mac      = 48'({$urandom(), $urandom()});
        sif.peer_ip       = $urandom();
    endtask

    // Wait for the frame to appear, check its launch latency/content, then step past the msync cycle
    task automatic frame_start(input string tag, input int exp_wait, input logic [3:0] ty,
                               input logic [47:0] mac, input logic [31:0] ip);
        int w = 0;
        while (sif.pkt_type === 4'd0 && w < int'(WAIT_MAX)) begin
            step();
            w++;
        end
        chk({tag, " latency"}, 64'(w), 64'(exp_wait));
        chk({tag, " type"}, 64'(sif.pkt_type), 64'(ty));
        chk({tag, " mac"}, 64'(sif.target_mac), 64'(mac));
        chk({tag, " ip"}, 64'(sif.target_ip), 64'(ip));
        chk({tag, " msync_n"}, 64'(sif.msync_n), (ty == 4'd3) ? 64'd0 : 64'd1);
        step();
        chk({tag, " msync_n release"}, 64'(sif.msync_n), 64'd1);
    endtask

    task automatic frame_end(input string tag, input int hold, input logic [3:0] ty,
                             input logic [47:0] mac);
        sif.tx_vld = 1'b1;
        for (int i = 0; i < hold; i++) begin
            chk({tag, " type held"}, 64'(sif.pkt_type), 64'(ty));
            chk({tag, " mac held"}, 64'(sif.target_mac), 64'(mac));
            step();
        end
        sif.tx_eop = 1'b1;
        step();
        sif.tx_vld = 1'b0;
        sif.tx_eop = 1'b0;
        chk({tag, " type cleared"}, 64'(sif.pkt_type), 64'd0);
        chk({tag, " busy in gap"}, 64'(sif.busy), 64'd1);
    endtask

    task automatic gap_to_idle(input string tag);
        for (int i = 0; i < int'(IFG) - 1; i++) step();
        chk({tag, " busy end of gap"}, 64'(sif.busy), 64'd1);
        step();
        chk({tag, " idle after gap"}, 64'(sif.busy), 64'd0);
        chk({tag, " type idle"}, 64'(sif.pkt_type), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " type"}, 64'(sif.pkt_type), 64'd0);
        chk({tag, " msync_n"}, 64'(sif.msync_n), 64'd1);
        chk({tag, " mac"}, 64'(sif.target_mac), 64'd0);
        chk({tag, " ip"}, 64'(sif.target_ip), 64'd0);
        chk({tag, " busy"}, 64'(sif.busy), 64'd0);
        chk({tag, " udp_drop"}, 64'(sif.udp_drop), 64'd0);
        chk({tag, " timeout_cnt"}, 64'(sif.timeout_cnt), 64'd0);
    endtask

    initial begin
        logic [47:0] hm;
        logic [31:0] hip;
        logic [47:0] pm;
        logic [31:0] pi;
        frm_t        exp_q[$];
        frm_t        f;
        int          cnt;

        hm  = 48'({$urandom(), $urandom()});
        hip = $urandom();
        rst = 1'b1;
        sif.arp_resp_req  = 1'b0;
        sif.udp_req       = 1'b0;
        sif.arp_probe_req = 1'b0;
        sif.peer_mac      = '0;
        sif.peer_ip       = '0;
        sif.host_ip       = hip;
        sif.host_mac      = hm;
        sif.host_mac_vld  = 1'b1;
        sif.tx_vld        = 1'b0;
        sif.tx_rdy        = 1'b1;
        sif.tx_eop        = 1'b0;
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();

        // Single UDP frame with resolved host MAC
        pulse(1'b0, 1'b1, 1'b0, '0, '0);
        frame_start("udp1", 2, 4'd3, hm, hip);
        frame_end("udp1", 4, 4'd3, hm);
        gap_to_idle("udp1");

        // ARP response and UDP in the same cycle: response first, UDP after the gap
        pm = 48'({$urandom(), $urandom()});
        pi = $urandom();
        pulse(1'b1, 1'b1, 1'b0, pm, pi);
        frame_start("resp", 2, 4'd2, pm, pi);
        frame_end("resp", 3, 4'd2, pm);
        frame_start("udp2", int'(IFG) + 2, 4'd3, hm, hip);
        frame_end("udp2", 2, 4'd3, hm);
        gap_to_idle("udp2");

        // Two UDP pulses during one frame: one more frame, one drop
        pulse(1'b0, 1'b1, 1'b0, '0, '0);
        frame_start("udp3", 2, 4'd3, hm, hip);
        pulse(1'b0, 1'b1, 1'b0, '0, '0);
        pulse(1'b0, 1'b1, 1'b0, '0, '0);
        chk("udp_drop after double pulse", 64'(sif.udp_drop), 64'd1);
        frame_end("udp3", 1, 4'd3, hm);
        frame_start("udp4", int'(IFG) + 2, 4'd3, hm, hip);
        frame_end("udp4", 0, 4'd3, hm);
        gap_to_idle("udp4");

        // Watchdog: sink never ready, EOP offered but never accepted
        sif.tx_rdy = 1'b0;
        pulse(1'b0, 1'b1, 1'b0, '0, '0);
        sif.tx_vld = 1'b1;
        sif.tx_eop = 1'b1;
        frame_start("tmo", 2, 4'd3, hm, hip);
        cnt = 1;
        while (sif.pkt_type !== 4'd0 && cnt < int'(WAIT_MAX)) begin
            cnt++;
            step();
        end
        sif.tx_vld = 1'b0;
        sif.tx_eop = 1'b0;
        sif.tx_rdy = 1'b1;
        chk("tmo frame duration", 64'(cnt), 64'(TMO));
        chk("tmo timeout_cnt", 64'(sif.timeout_cnt), 64'd1);
        chk("tmo type", 64'(sif.pkt_type), 64'd0);
        gap_to_idle("tmo");

        // Unresolved host MAC: UDP waits, probe goes to broadcast, UDP follows once resolved
        sif.host_mac_vld = 1'b0;
        pulse(1'b0, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) step();
        chk("unresolved udp busy", 64'(sif.busy), 64'd0);
        chk("unresolved udp type", 64'(sif.pkt_type), 64'd0);
        pulse(1'b0, 1'b0, 1'b1, '0, '0);
        frame_start("probe", 2, 4'd1, BCAST, hip);
        frame_end("probe", 2, 4'd1, BCAST);
        gap_to_idle("probe");
        for (int i = 0; i < 4; i++) step();
        chk("udp still blocked", 64'(sif.busy), 64'd0);
        sif.host_mac_vld = 1'b1;
        frame_start("udp late", 2, 4'd3, hm, hip);
        frame_end("udp late", 1, 4'd3, hm);
        gap_to_idle("udp late");

        // Randomized request sets against the priority-order model
        for (int it = 0; it < 24; it++) begin
            logic arp, udp, probe, vld;
            arp   = 1'($urandom_range(0, 1));
            udp   = 1'($urandom_range(0, 1));
            probe = 1'($urandom_range(0, 1));
            vld   = 1'($urandom_range(0, 1));
            if (!(arp || udp || probe)) probe = 1'b1;
            hm  = 48'({$urandom(), $urandom()});
            hip = $urandom();
            pm  = 48'({$urandom(), $urandom()});
            pi  = $urandom();
            sif.host_mac     = hm;
            sif.host_ip      = hip;
            sif.host_mac_vld = vld;
            exp_q.delete();
            if (arp) exp_q.push_back('{t: 4'd2, mac: pm, ip: pi});
            if (udp && vld) exp_q.push_back('{t: 4'd3, mac: hm, ip: hip});
            if (probe) exp_q.push_back('{t: 4'd1, mac: (vld ? hm : BCAST), ip: hip});
            pulse(arp, udp, probe, pm, pi);
            if (exp_q.size() == 0) begin
                for (int i = 0; i < 4; i++) step();
                chk($sformatf("rnd%0d no launch", it), 64'(sif.busy), 64'd0);
            end else begin
                for (int k = 0; exp_q.size() > 0; k++) begin
                    f = exp_q.pop_front();
                    frame_start($sformatf("rnd%0d f%0d", it, k), (k == 0) ? 2 : int'(IFG) + 2,
                                f.t, f.mac, f.ip);
                    frame_end($sformatf("rnd%0d f%0d", it, k), int'($urandom_range(0, 6)), f.t, f.mac);
                end
                gap_to_idle($sformatf("rnd%0d", it));
            end
            if (udp && !vld) begin
                sif.host_mac_vld = 1'b1;
                frame_start($sformatf("rnd%0d deferred udp", it), 2, 4'd3, hm, hip);
                frame_end($sformatf("rnd%0d deferred udp", it), int'($urandom_range(0, 6)), 4'd3, hm);
                gap_to_idle($sformatf("rnd%0d deferred udp", it));
            end
        end
        chk("final udp_drop", 64'(sif.udp_drop), 64'd1);
        chk("final timeout_cnt", 64'(sif.timeout_cnt), 64'd1);

        // Synchronous reset in the middle of a frame with requests pending
        sif.host_mac_vld = 1'b1;
        pulse(1'b0, 1'b1, 1'b0, '0, '0);
        frame_start("pre-rst", 2, 4'd3, hm, hip);
        pulse(1'b1, 1'b1, 1'b1, 48'h0123_4567_89AB, 32'hC0A8_0001);
        rst = 1'b1;
        step();
        chk_reset_vals("mid-send reset");
        rst = 1'b0;
        for (int i = 0; i < int'(IFG) + 5; i++) step();
        chk("post-rst busy", 64'(sif.busy), 64'd0);
        chk("post-rst type", 64'(sif.pkt_type), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
